ma_mem_ctrl: RTL

- Memory-access-stage controller between the EX/MA pipeline register outputs and a single-ported data memory with a req/ack handshake.
- Decodes the 2-bit MEM_READ/MEM_WRITE size codes, aligns data and byte enables, and sequences multi-cycle accesses.
- Stalls the pipeline until each access completes, then returns load data formatted for writeback.
- Detects misaligned, conflicting and timed-out accesses.

---
 rtl/ma_mem_ctrl_if.sv | 21 ++
 rtl/ma_mem_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ma_mem_ctrl_if.sv
// Data-memory side bus of the MA-stage controller: single-ported memory with req/ack handshake.
// The controller drives the request side (master); the memory returns read data and ack (slave).
interface ma_mem_ctrl_if;
    logic        DM_REQ;
    logic        DM_WE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [3:0]  DM_BYTE_EN;
    logic [31:0] DM_RDATA;
    logic        DM_ACK;

    modport master (
        output DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BYTE_EN,
        input  DM_RDATA, DM_ACK
    );

    modport slave (
        input  DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BYTE_EN,
        output DM_RDATA, DM_ACK
    );
endinterface

// File: rtl/ma_mem_ctrl.sv
// Memory-access-stage controller: decodes load/store size, aligns lanes, sequences the
// req/ack transfer, stalls the pipeline until completion and formats load data.
module ma_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [1:0]    MEM_READ,
    input  logic [1:0]    MEM_WRITE,
    input  logic          LOAD_UNSIGNED,
    input  logic [31:0]   ADDRESS,
    input  logic [31:0]   WRITE_DATA,
    ma_mem_ctrl_if.master dm,
    output logic          STALL,
    output logic [31:0]   READ_DATA,
    output logic          ACCESS_ERR,
    output logic          BUS_ERR
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  size_q, size_d, off_q, off_d;
    logic        uns_q, uns_d;
    logic        acc_err_q, acc_err_d, bus_err_q, bus_err_d;

    logic        rd_act, wr_act, misalign, conflict, valid, viol;
    logic [1:0]  size, off;
    logic [3:0]  be_sel;
    logic [31:0] wdata_sel, shifted, load_fmt;

    assign rd_act   = |MEM_READ;
    assign wr_act   = |MEM_WRITE;
    assign size     = wr_act ? MEM_WRITE : MEM_READ;
    assign off      = ADDRESS[1:0];
    assign misalign = ((size == 2'b10) && off[0]) || ((size == 2'b11) && (off != 2'b00));
    assign conflict = rd_act && wr_act;
    assign valid    = (rd_act ^ wr_act) && !misalign;
    assign viol     = conflict || ((rd_act || wr_act) && misalign);

    always_comb begin
        be_sel    = 4'b1111;
        wdata_sel = WRITE_DATA;
        case (size)
            2'b01: begin
                be_sel    = 4'b0001 << off;
                wdata_sel = {4{WRITE_DATA[7:0]}};
            end
            2'b10: begin
                be_sel    = 4'b0011 << off;
                wdata_sel = {2{WRITE_DATA[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting uses the size/offset/extension captured in IDLE, not the live inputs.
    assign shifted = dm.DM_RDATA >> {off_q, 3'b000};
    always_comb begin
        load_fmt = shifted;
        case (size_q)
            2'b01:   load_fmt = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b10:   load_fmt = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        size_d    = size_q;
        off_d     = off_q;
        uns_d     = uns_q;
        acc_err_d = 1'b0;
        bus_err_d = 1'b0;
        STALL     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    STALL   = 1'b1;
                    state_d = S_ACCESS;
                    req_d   = 1'b1;
                    we_d    = wr_act;
                    addr_d  = {ADDRESS[31:2], 2'b00};
                    wdata_d = wdata_sel;
                    be_d    = be_sel;
                    size_d  = size;
                    off_d   = off;
                    uns_d   = LOAD_UNSIGNED;
                    cnt_d   = '0;
                end else if (viol) begin
                    acc_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            S_ACCESS: begin
                STALL = 1'b1;
                // Ack wins over a timeout expiring in the same cycle.
                if (dm.DM_ACK) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    rdata_d = we_q ? '0 : load_fmt;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            size_q    <= '0;
            off_q     <= '0;
            uns_q     <= 1'b0;
            acc_err_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            size_q    <= size_d;
            off_q     <= off_d;
            uns_q     <= uns_d;
            acc_err_q <= acc_err_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dm.DM_REQ     = req_q;
    assign dm.DM_WE      = we_q;
    assign dm.DM_ADDR    = addr_q;
    assign dm.DM_WDATA   = wdata_q;
    assign dm.DM_BYTE_EN = be_q;
    assign READ_DATA     = rdata_q;
    assign ACCESS_ERR    = acc_err_q;
    assign BUS_ERR       = bus_err_q;
endmodule
